mem_cache_ctrl: RTL and testbench
=================================

MEM_CACHE_CTRL -- requirements
Module: mem_cache_ctrl

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, main-memory access time in cycles, legal range 1..64.
REQ-002 SHALL have parameter WRITE_ALLOCATE, default 1: 1 = store miss installs into cache; 0 = store miss writes around the cache to memory.
REQ-003 SHALL have parameter CNT_W, default 16, width of the miss counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port opcode  input  6  instruction opcode: LW 100011, SW 101011, LB 100000, SB 101000; all others are non-memory.
REQ-007 SHALL have ports cache_hit, cache_dirty  input  1 each  tag-match result and dirty bit of the indexed line.
REQ-008 SHALL have outputs we_memory, we_cache, cache_input_type, memory_address_type, is_word, register_write, set_dirty, set_valid, pc_enable, lock, each 1 bit.
REQ-009 SHALL have output miss_count  output  CNT_W  count of load and store misses since reset.

Function
REQ-010 SHALL implement states IDLE, WB, FILL, INSTALL, RESP, WAROUND; outputs SHALL be fully combinational from state, op_q and inputs, with no inferred latches.
REQ-011 Default output values in every state SHALL be: we_memory=0, we_cache=0, cache_input_type=1, memory_address_type=0, register_write=0, set_dirty=0, set_valid=0, pc_enable=0, lock=1, is_word = (op is LW or SW).
REQ-012 In IDLE, SHALL use opcode directly; on leaving IDLE, SHALL capture the opcode into op_q, and all other states SHALL decode op_q only, so that mid-miss opcode changes are ignored.
REQ-013 IDLE, non-memory opcode: pc_enable=1, lock=0, stay in IDLE.
REQ-014 IDLE, load hit: register_write=1, pc_enable=1, lock=0, stay in IDLE.
REQ-015 IDLE, store hit, or store miss with clean line and WRITE_ALLOCATE=1: we_cache=1, set_dirty=1, set_valid=1, pc_enable=1, lock=0, stay in IDLE.
REQ-016 IDLE, any miss with dirty line: go to WB, pc_enable=0, lock=1.
REQ-017 IDLE, load miss with clean line: go to FILL.
REQ-018 IDLE, store miss with WRITE_ALLOCATE=0: go to WAROUND regardless of dirty; the cache line SHALL NOT be modified.
REQ-019 Each of WB, FILL and WAROUND SHALL last exactly MEM_LATENCY cycles, using a down-counter loaded with MEM_LATENCY-1 on entry and exiting when the counter reaches 0.
REQ-020 WB: we_memory=1 and memory_address_type=1 (victim address) for every cycle; exit to FILL for a load, or to INSTALL for a store.
REQ-021 FILL: memory_address_type=0 (request address), we_memory=0; exit to INSTALL.
REQ-022 INSTALL, load: we_cache=1, cache_input_type=0, is_word=1, set_valid=1, set_dirty=0, go to RESP.
REQ-023 INSTALL, store: we_cache=1, cache_input_type=1, set_valid=1, set_dirty=1, pc_enable=1, lock=0, go to IDLE.
REQ-024 RESP: register_write=1, pc_enable=1, lock=0, go to IDLE.
REQ-025 WAROUND: we_memory=1, memory_address_type=0 for every cycle; on its last cycle pc_enable=1 and lock=0, then go to IDLE.
REQ-026 miss_count SHALL increment by 1 on each IDLE cycle that leaves IDLE, and SHALL saturate at all-ones.
REQ-027 An unreachable state encoding SHALL return to IDLE on the next cycle with default outputs.

Reset
REQ-028 While rst_n=0, SHALL force state=IDLE, op_q=0, counter=0, miss_count=0, independent of clk.
REQ-029 Reset asserted mid-miss SHALL abandon the operation with no further we_memory or we_cache; the first cycle after release SHALL behave as IDLE.

Structure
REQ-030 Package cache_ctrl_pkg SHALL hold the opcode constants, the state enum, and an is_load/is_store helper function.
REQ-031 The latency down-counter SHALL be a sub-module mem_wait_counter (inputs load and MEM_LATENCY; output done).

Verification (MEM_LATENCY=4; cycle 0 = miss detected in IDLE)
REQ-032 LW miss, clean -> FILL in cycles 1-4, INSTALL in cycle 5 (we_cache=1, cache_input_type=0), RESP in cycle 6 (register_write=1, pc_enable=1); pc_enable=0 in cycles 0-5; miss_count=1.
REQ-033 LB miss, dirty -> WB in cycles 1-4 with we_memory=1 and memory_address_type=1, FILL in cycles 5-8, INSTALL in cycle 9, RESP in cycle 10 with is_word=0.
REQ-034 SW miss, dirty, WRITE_ALLOCATE=1 -> WB in cycles 1-4, INSTALL in cycle 5 with set_dirty=1 and pc_enable=1, IDLE in cycle 6.
REQ-035 SB miss, WRITE_ALLOCATE=0 -> we_memory=1 in cycles 1-4, we_cache never asserted, pc_enable=1 in cycle 4.
REQ-036 LW miss with opcode switched to 000000 in cycle 2 -> sequence identical to REQ-032; rst_n pulsed low in cycle 3 of a repeat run -> IDLE, lock=0, miss_count=0, no further writes.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache miss controller: memory opcodes,
// controller state encoding and opcode classification helpers.
package cache_ctrl_pkg;

   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] OP_LB = 6'b100000;
   localparam logic [5:0] OP_SB = 6'b101000;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WB      = 3'd1,
      S_FILL    = 3'd2,
      S_INSTALL = 3'd3,
      S_RESP    = 3'd4,
      S_WAROUND = 3'd5
   } state_e;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_LB);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_SB);
   endfunction

   function automatic logic is_word_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Main-memory wait timer. A pulse on load starts a MEM_LATENCY-cycle window:
// the counter takes MEM_LATENCY-1 and counts down, and done is high while it
// sits at zero, i.e. on the last cycle of the window (and whenever idle).
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the counter
//   load  : restart the window on the next edge
//   done  : terminal count reached
module mem_wait_counter #(
   parameter int MEM_LATENCY = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic done
);

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LATENCY - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mem_cache_ctrl.sv
// Cache controller for a single-issue pipeline: resolves load/store hits in
// one cycle and sequences write-back, line fill, install and write-around on
// misses while stalling the PC.
//   clk, rst_n            : clock, asynchronous active-low reset
//   opcode                : instruction opcode (only sampled while idle)
//   cache_hit, cache_dirty: tag match / dirty bit of the indexed line
//   we_memory, we_cache   : memory / cache write enables
//   cache_input_type      : 0 = line from memory, 1 = store data
//   memory_address_type   : 0 = request address, 1 = victim address
//   is_word, register_write, set_dirty, set_valid : datapath controls
//   pc_enable, lock       : pipeline advance / stall
//   miss_count            : saturating count of misses since reset
//
// state   | meaning
// IDLE    | decode current opcode, serve hits, launch misses
// WB      | write dirty victim line back to memory
// FILL    | read requested line from memory
// INSTALL | write filled line or store data into the cache
// RESP    | return load data to the register file
// WAROUND | store miss bypassing the cache straight to memory
module mem_cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int MEM_LATENCY    = 4,
   parameter bit WRITE_ALLOCATE = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             cache_hit,
   input  logic             cache_dirty,
   output logic             we_memory,
   output logic             we_cache,
   output logic             cache_input_type,
   output logic             memory_address_type,
   output logic             is_word,
   output logic             register_write,
   output logic             set_dirty,
   output logic             set_valid,
   output logic             pc_enable,
   output logic             lock,
   output logic [CNT_W-1:0] miss_count
);

   localparam logic [2:0] ST_IDLE    = S_IDLE;
   localparam logic [2:0] ST_WB      = S_WB;
   localparam logic [2:0] ST_FILL    = S_FILL;
   localparam logic [2:0] ST_INSTALL = S_INSTALL;
   localparam logic [2:0] ST_RESP    = S_RESP;
   localparam logic [2:0] ST_WAROUND = S_WAROUND;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [5:0] op_q;
   logic [5:0] op;
   logic       op_load;
   logic       op_store;
   logic       cnt_load;
   logic       cnt_done;
   logic       leave_idle;

   // Only the idle cycle looks at the live opcode; once a miss is under way
   // the pipeline may present anything and the captured opcode rules.
   assign op       = (state == ST_IDLE) ? opcode : op_q;
   assign op_load  = is_load(op);
   assign op_store = is_store(op);

   mem_wait_counter #(
      .MEM_LATENCY(MEM_LATENCY)
   ) u_wait (
      .clk  (clk),
      .rst_n(rst_n),
      .load (cnt_load),
      .done (cnt_done)
   );

   always_comb begin
      state_nxt           = ST_IDLE;
      cnt_load            = 1'b0;
      we_memory           = 1'b0;
      we_cache            = 1'b0;
      cache_input_type    = 1'b1;
      memory_address_type = 1'b0;
      is_word             = is_word_op(op);
      register_write      = 1'b0;
      set_dirty           = 1'b0;
      set_valid           = 1'b0;
      pc_enable           = 1'b0;
      lock                = 1'b1;

      case (state)
         ST_IDLE: begin
            state_nxt = ST_IDLE;
            if (op_load && cache_hit) begin
               register_write = 1'b1;
               pc_enable      = 1'b1;
               lock           = 1'b0;
            end else if (op_store && (cache_hit || (WRITE_ALLOCATE && !cache_dirty))) begin
               // A clean victim can simply be overwritten by the store.
               we_cache  = 1'b1;
               set_dirty = 1'b1;
               set_valid = 1'b1;
               pc_enable = 1'b1;
               lock      = 1'b0;
            end else if (op_store && !WRITE_ALLOCATE) begin
               state_nxt = ST_WAROUND;
               cnt_load  = 1'b1;
            end else if ((op_load || op_store) && cache_dirty) begin
               state_nxt = ST_WB;
               cnt_load  = 1'b1;
            end else if (op_load) begin
               state_nxt = ST_FILL;
               cnt_load  = 1'b1;
            end else begin
               pc_enable = 1'b1;
               lock      = 1'b0;
            end
         end

         ST_WB: begin
            we_memory           = 1'b1;
            memory_address_type = 1'b1;
            if (cnt_done) begin
               state_nxt = op_load ? ST_FILL : ST_INSTALL;
               cnt_load  = op_load;
            end else begin
               state_nxt = ST_WB;
            end
         end

         ST_FILL: begin
            state_nxt = cnt_done ? ST_INSTALL : ST_FILL;
         end

         ST_INSTALL: begin
            we_cache  = 1'b1;
            set_valid = 1'b1;
            if (op_load) begin
               // Whole line comes from memory regardless of access size.
               cache_input_type = 1'b0;
               is_word          = 1'b1;
               state_nxt        = ST_RESP;
            end else begin
               set_dirty = 1'b1;
               pc_enable = 1'b1;
               lock      = 1'b0;
               state_nxt = ST_IDLE;
            end
         end

         ST_RESP: begin
            register_write = 1'b1;
            pc_enable      = 1'b1;
            lock           = 1'b0;
            state_nxt      = ST_IDLE;
         end

         ST_WAROUND: begin
            we_memory = 1'b1;
            if (cnt_done) begin
               pc_enable = 1'b1;
               lock      = 1'b0;
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_WAROUND;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   assign leave_idle = (state == ST_IDLE) && (state_nxt != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         op_q       <= '0;
         miss_count <= '0;
      end else begin
         state <= state_nxt;
         if (leave_idle) begin
            op_q <= opcode;
            if (miss_count != '1) begin
               miss_count <= miss_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Bench for mem_cache_ctrl: two instances (write-allocate with a 4-bit miss
// counter, write-around with an 8-bit counter), directed cycle sequences,
// reset abort, then randomized traffic checked by a scoreboard against a
// transaction-level model.
module tb_mem_cache_ctrl;
   import cache_ctrl_pkg::*;

   localparam int L = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [1:0][5:0] opc;
   logic [1:0]      hit, dirty;
   logic [1:0]      wm, wc, cit, mat, iw, rw, sd, sv, pe, lk;
   logic [3:0]      mc0;
   logic [7:0]      mc1;

   mem_cache_ctrl #(.MEM_LATENCY(L), .WRITE_ALLOCATE(1'b1), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .opcode(opc[0]), .cache_hit(hit[0]), .cache_dirty(dirty[0]),
      .we_memory(wm[0]), .we_cache(wc[0]), .cache_input_type(cit[0]),
      .memory_address_type(mat[0]), .is_word(iw[0]), .register_write(rw[0]),
      .set_dirty(sd[0]), .set_valid(sv[0]), .pc_enable(pe[0]), .lock(lk[0]),
      .miss_count(mc0));

   mem_cache_ctrl #(.MEM_LATENCY(L), .WRITE_ALLOCATE(1'b0), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .opcode(opc[1]), .cache_hit(hit[1]), .cache_dirty(dirty[1]),
      .we_memory(wm[1]), .we_cache(wc[1]), .cache_input_type(cit[1]),
      .memory_address_type(mat[1]), .is_word(iw[1]), .register_write(rw[1]),
      .set_dirty(sd[1]), .set_valid(sv[1]), .pc_enable(pe[1]), .lock(lk[1]),
      .miss_count(mc1));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic int mcnt(input int k);
      return (k == 0) ? int'(mc0) : int'(mc1);
   endfunction

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      int lat;     // cycles from issue until pc_enable
      int wm;      // cycles with we_memory
      int vic;     // cycles writing the victim address
      int wc;      // cycles with we_cache
      int wcfill;  // cycles installing a memory line
      int rw;      // register_write at completion
      int iw;      // is_word at completion
      int sd;      // set_dirty / set_valid at completion
      int mc;      // miss_count at completion
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   miss_n[2];
   int   mc_max[2] = '{15, 255};

   task automatic model(input int k, input logic [5:0] op, input bit h, input bit d,
                        output exp_t e);
      bit ld, st, wa, miss;
      int wb;
      ld   = (op == OP_LW) || (op == OP_LB);
      st   = (op == OP_SW) || (op == OP_SB);
      wa   = (k == 0);
      miss = 1'b0;
      e    = '{default: 0};
      e.iw = (op == OP_LW) || (op == OP_SW);
      if (ld && h) begin
         e.rw = 1;
      end else if (st && (h || (wa && !d))) begin
         e.wc = 1; e.sd = 1;
      end else if (ld) begin
         miss = 1'b1;
         wb = d ? L : 0;
         e.lat = wb + L + 2;
         e.wm = wb; e.vic = wb; e.wc = 1; e.wcfill = 1; e.rw = 1;
      end else if (st && wa) begin
         miss = 1'b1;
         e.lat = L + 1; e.wm = L; e.vic = L; e.wc = 1; e.sd = 1;
      end else if (st) begin
         miss = 1'b1;
         e.lat = L; e.wm = L;
      end
      if (miss && miss_n[k] < mc_max[k]) miss_n[k]++;
      e.mc = miss_n[k];
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit mon_en[2];
   int idx[2], a_wm[2], a_vic[2], a_wc[2], a_fill[2];

   always @(negedge clk) begin : monitor
      exp_t e;
      bit   got;
      for (int k = 0; k < 2; k++) begin
         if (mon_en[k]) begin
            a_wm[k]   += int'(wm[k]);
            a_vic[k]  += int'(wm[k] & mat[k]);
            a_wc[k]   += int'(wc[k]);
            a_fill[k] += int'(wc[k] & ~cit[k]);
            if (pe[k]) begin
               got = 1'b0;
               if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
               if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
               if (!got) begin
                  checks++; errors++;
                  $display("FAIL i%0d_scoreboard actual unexpected completion required none", k);
               end else begin
                  check($sformatf("i%0d_latency", k), idx[k], e.lat);
                  check($sformatf("i%0d_we_memory_cycles", k), a_wm[k], e.wm);
                  check($sformatf("i%0d_victim_cycles", k), a_vic[k], e.vic);
                  check($sformatf("i%0d_we_cache_cycles", k), a_wc[k], e.wc);
                  check($sformatf("i%0d_fill_install_cycles", k), a_fill[k], e.wcfill);
                  check($sformatf("i%0d_register_write", k), int'(rw[k]), e.rw);
                  check($sformatf("i%0d_is_word", k), int'(iw[k]), e.iw);
                  check($sformatf("i%0d_set_dirty", k), int'(sd[k]), e.sd);
                  check($sformatf("i%0d_set_valid", k), int'(sv[k]), e.sd);
                  check($sformatf("i%0d_lock", k), int'(lk[k]), 0);
                  check($sformatf("i%0d_miss_count", k), mcnt(k), e.mc);
               end
               idx[k] = 0; a_wm[k] = 0; a_vic[k] = 0; a_wc[k] = 0; a_fill[k] = 0;
            end else begin
               idx[k]++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Entered and left at posedge+2; holds the opcode for cycle 0 only, then
   // scrambles all inputs each cycle until the instruction completes.
   task automatic run_txn(input int k, input logic [5:0] op, input bit h, input bit d);
      exp_t e;
      int   n;
      model(k, op, h, d, e);
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      opc[k] = op; hit[k] = h; dirty[k] = d;
      n = 0;
      @(negedge clk);
      while (!pe[k] && n < 200) begin
         @(posedge clk); #2;
         opc[k] = 6'($urandom); hit[k] = 1'($urandom); dirty[k] = 1'($urandom);
         @(negedge clk);
         n++;
      end
      if (!pe[k]) begin
         checks++; errors++;
         $display("FAIL i%0d_txn_timeout actual no pc_enable required completion", k);
      end
      @(posedge clk); #2;
   endtask

   task automatic drive_random(input int k, input int ntx);
      logic [5:0] op;
      mon_en[k] = 1'b1;
      for (int i = 0; i < ntx; i++) begin
         case ($urandom_range(0, 9))
            0, 1:    op = OP_LW;
            2, 3:    op = OP_SW;
            4, 5:    op = OP_LB;
            6, 7:    op = OP_SB;
            default: op = 6'($urandom);
         endcase
         run_txn(k, op, 1'($urandom), 1'($urandom));
      end
      mon_en[k] = 1'b0;
      opc[k] = 6'd0;
   endtask

   // Cycle-exact sequence; bit c of each vector is the value in cycle c.
   // The opcode is replaced by 000000 from cycle sw onward.
   task automatic dir_run(input string nm, input int k, input logic [5:0] op,
                          input bit h, input bit d, input int ncyc, input int sw,
                          input logic [15:0] x_pe, input logic [15:0] x_wc,
                          input logic [15:0] x_fill, input logic [15:0] x_wm,
                          input logic [15:0] x_vic, input logic [15:0] x_rw,
                          input logic [15:0] x_iw, input logic [15:0] x_sd);
      opc[k] = op; hit[k] = h; dirty[k] = d;
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) begin
            @(posedge clk); #2;
            if (c >= sw) opc[k] = 6'd0;
         end
         @(negedge clk);
         check($sformatf("%s_c%0d_pc_enable", nm, c), int'(pe[k]), int'(x_pe[c]));
         check($sformatf("%s_c%0d_we_cache", nm, c), int'(wc[k]), int'(x_wc[c]));
         check($sformatf("%s_c%0d_fill_install", nm, c), int'(wc[k] & ~cit[k]), int'(x_fill[c]));
         check($sformatf("%s_c%0d_we_memory", nm, c), int'(wm[k]), int'(x_wm[c]));
         check($sformatf("%s_c%0d_victim_write", nm, c), int'(wm[k] & mat[k]), int'(x_vic[c]));
         check($sformatf("%s_c%0d_register_write", nm, c), int'(rw[k]), int'(x_rw[c]));
         check($sformatf("%s_c%0d_is_word", nm, c), int'(iw[k]), int'(x_iw[c]));
         check($sformatf("%s_c%0d_set_dirty", nm, c), int'(sd[k]), int'(x_sd[c]));
      end
      @(posedge clk); #2;
      opc[k] = 6'd0; hit[k] = 1'b0; dirty[k] = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual simulation still running required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst_n = 1'b0;
      opc   = '0;
      hit   = '0;
      dirty = '0;
      #12;
      check("reset_miss_count0", int'(mc0), 0);
      check("reset_miss_count1", int'(mc1), 0);
      check("reset_pc_enable", int'(pe), 3);
      check("reset_lock", int'(lk), 0);
      check("reset_we_memory", int'(wm), 0);
      check("reset_we_cache", int'(wc), 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;

      dir_run("lw_miss_clean", 0, OP_LW, 1'b0, 1'b0, 7, 2,
              16'h0040, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 16'h0040, 16'h007F, 16'h0000);
      check("lw_miss_clean_miss_count", int'(mc0), 1);
      dir_run("lb_miss_dirty", 0, OP_LB, 1'b0, 1'b1, 11, 1,
              16'h0400, 16'h0200, 16'h0200, 16'h001E, 16'h001E, 16'h0400, 16'h0200, 16'h0000);
      check("lb_miss_dirty_miss_count", int'(mc0), 2);
      dir_run("sw_miss_dirty", 0, OP_SW, 1'b0, 1'b1, 7, 1,
              16'h0060, 16'h0020, 16'h0000, 16'h001E, 16'h001E, 16'h0000, 16'h003F, 16'h0020);
      check("sw_miss_dirty_miss_count", int'(mc0), 3);
      dir_run("sb_waround", 1, OP_SB, 1'b0, 1'b1, 5, 1,
              16'h0010, 16'h0000, 16'h0000, 16'h001E, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("sb_waround_miss_count", int'(mc1), 1);

      // reset abort in cycle 3 of a miss on both instances
      opc[0] = OP_LW; hit[0] = 1'b0; dirty[0] = 1'b0;
      opc[1] = OP_SB; hit[1] = 1'b0; dirty[1] = 1'b0;
      @(posedge clk); #2;
      opc = '0;
      @(posedge clk); #2;
      @(posedge clk); #2;
      check("abort_pre_waround_active", int'(wm[1]), 1);
      rst_n = 1'b0;
      #1;
      check("abort_lock", int'(lk), 0);
      check("abort_miss_count0", int'(mc0), 0);
      check("abort_miss_count1", int'(mc1), 0);
      check("abort_we_memory", int'(wm), 0);
      check("abort_we_cache", int'(wc), 0);
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("post_abort_c%0d_we_memory", c), int'(wm), 0);
         check($sformatf("post_abort_c%0d_we_cache", c), int'(wc), 0);
         check($sformatf("post_abort_c%0d_pc_enable", c), int'(pe), 3);
         check($sformatf("post_abort_c%0d_miss_count", c), mcnt(0) + mcnt(1), 0);
      end
      @(posedge clk); #2;
      miss_n[0] = 0;
      miss_n[1] = 0;

      fork
         drive_random(0, 150);
         drive_random(1, 150);
      join
      repeat (3) @(posedge clk);
      check("scoreboard_drained0", q0.size(), 0);
      check("scoreboard_drained1", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
